// File: rtl/msdap_frame_tx.sv
`default_nettype none
// ============================================================================
// Module      : msdap_frame_tx
// Description : Multi-channel serial frame transmitter for the MSDAP serial
//               input port. Sequences the Rj, coefficient and data load
//               phases and serialises one parallel word per frame, MSB first,
//               with Frame marking the MSB bit.
//
// Ports
//   Dclk          bit clock, one serial bit per rising edge
//   Reset_n       asynchronous active-low reset
//   start         one-cycle pulse, begins a load sequence from IDLE
//   skip_cfg      sampled with start; 1 = go straight to the data phase
//   dut_in_ready  MSDAP InReady; releases the wait state
//   word_valid    upstream word available
//   word_data     channel c in bits [c*FRAME_W +: FRAME_W]
//   word_rst      data-phase only: pulse Reset_out during this frame
//   word_ready    word taken when word_valid & word_ready
//   Frame         high during the MSB bit of each frame
//   Input         serial data, one bit per channel
//   Reset_out     in-band reset pulse, one bit cycle at bit RST_BIT
//   phase         0 idle/wait, 1 Rj, 2 coefficients, 3 data
//   underrun      sticky, set when a frame boundary finds no word
//
// Revision    : 1.0  initial release
// ============================================================================
module msdap_frame_tx #(
    parameter int CHANNELS   = 2,
    parameter int FRAME_W    = 16,
    parameter int RJ_WORDS   = 16,
    parameter int RJ_BITS    = 8,
    parameter int COEF_WORDS = 512,
    parameter int COEF_BITS  = 9,
    parameter int RST_BIT    = 13
) (
    input  logic                        Dclk,
    input  logic                        Reset_n,
    input  logic                        start,
    input  logic                        skip_cfg,
    input  logic                        dut_in_ready,
    input  logic                        word_valid,
    input  logic [CHANNELS*FRAME_W-1:0] word_data,
    input  logic                        word_rst,
    output logic                        word_ready,
    output logic                        Frame,
    output logic [CHANNELS-1:0]         Input,
    output logic                        Reset_out,
    output logic [1:0]                  phase,
    output logic                        underrun
);

    localparam int c_max_words = (RJ_WORDS > COEF_WORDS) ? RJ_WORDS : COEF_WORDS;
    localparam int c_wcnt_w    = (c_max_words > 1) ? $clog2(c_max_words) : 1;
    localparam int c_bcnt_w    = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;

    localparam logic [c_bcnt_w-1:0] c_bit_msb   = c_bcnt_w'(FRAME_W - 1);
    localparam logic [c_bcnt_w-1:0] c_bit_rst   = c_bcnt_w'(RST_BIT);
    localparam logic [c_wcnt_w-1:0] c_rj_last   = c_wcnt_w'(RJ_WORDS - 1);
    localparam logic [c_wcnt_w-1:0] c_coef_last = c_wcnt_w'(COEF_WORDS - 1);
    localparam logic [FRAME_W-1:0]  c_rj_mask   = FRAME_W'((64'd1 << RJ_BITS) - 64'd1);
    localparam logic [FRAME_W-1:0]  c_coef_mask = FRAME_W'((64'd1 << COEF_BITS) - 64'd1);

    // Low two bits of the state code are the phase output, so phase is a
    // direct register slice.
    localparam logic [2:0] c_st_idle = 3'b000;
    localparam logic [2:0] c_st_wait = 3'b100;
    localparam logic [2:0] c_st_rj   = 3'b001;
    localparam logic [2:0] c_st_coef = 3'b010;
    localparam logic [2:0] c_st_data = 3'b011;

    logic [2:0]          r_state;
    logic                r_skip;
    logic                r_word_ready;
    logic                r_active;
    logic [c_bcnt_w-1:0] r_bitcnt;
    logic [c_wcnt_w-1:0] r_wcnt;
    logic                r_last;
    logic                r_frame;
    logic                r_rst_pend;
    logic                r_reset_out;
    logic                r_underrun;

    logic                w_in_phase;
    logic                w_accept;
    logic                w_boundary;
    logic                w_phase_end;
    logic [2:0]          w_next_state;
    logic [2:0]          w_cur_state;
    logic [c_wcnt_w-1:0] w_wcnt_base;
    logic                w_last_word;
    logic                w_shift;
    logic                w_clear;
    logic                w_rst_en;
    logic [c_bcnt_w-1:0] w_bit_dec;
    logic [FRAME_W-1:0]  w_mask;

    // A word accepted on the last bit of a phase's final frame already
    // belongs to the following phase, so masking and word counting use the
    // phase that will be current after this edge (w_cur_state).
    always_comb begin
        w_in_phase   = (r_state == c_st_rj) || (r_state == c_st_coef) ||
                       (r_state == c_st_data);
        w_accept     = w_in_phase && r_word_ready && word_valid;
        w_boundary   = r_active && (r_bitcnt == '0);
        w_phase_end  = w_boundary && r_last;
        w_next_state = (r_state == c_st_rj) ? c_st_coef : c_st_data;
        w_cur_state  = w_phase_end ? w_next_state : r_state;
        w_wcnt_base  = w_phase_end ? '0 : r_wcnt;
        w_last_word  = ((w_cur_state == c_st_rj)   && (w_wcnt_base == c_rj_last)) ||
                       ((w_cur_state == c_st_coef) && (w_wcnt_base == c_coef_last));
        w_shift      = w_in_phase && !w_accept && r_active && (r_bitcnt != '0);
        w_clear      = w_in_phase && !w_accept && !w_shift;
        w_rst_en     = (w_cur_state == c_st_data) && word_rst;
        w_bit_dec    = r_bitcnt - c_bcnt_w'(1);
        if (w_cur_state == c_st_rj) begin
            w_mask = c_rj_mask;
        end else if (w_cur_state == c_st_coef) begin
            w_mask = c_coef_mask;
        end else begin
            w_mask = '1;
        end
    end

    // Control and sequencing
    always_ff @(posedge Dclk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state      <= c_st_idle;
            r_skip       <= 1'b0;
            r_word_ready <= 1'b0;
            r_active     <= 1'b0;
            r_bitcnt     <= '0;
            r_wcnt       <= '0;
            r_last       <= 1'b0;
            r_frame      <= 1'b0;
            r_rst_pend   <= 1'b0;
            r_reset_out  <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_skip  <= skip_cfg;
                        r_state <= c_st_wait;
                    end
                end
                c_st_wait: begin
                    if (dut_in_ready) begin
                        r_state      <= r_skip ? c_st_data : c_st_rj;
                        r_word_ready <= 1'b1;
                    end
                end
                c_st_rj, c_st_coef, c_st_data: begin
                    if (w_phase_end) begin
                        r_state <= w_next_state;
                        r_last  <= 1'b0;
                        r_wcnt  <= '0;
                    end
                    if (w_accept) begin
                        r_active     <= 1'b1;
                        r_bitcnt     <= c_bit_msb;
                        r_frame      <= 1'b1;
                        r_word_ready <= 1'b0;
                        r_rst_pend   <= w_rst_en;
                        r_reset_out  <= w_rst_en && (c_bit_msb == c_bit_rst);
                        // The data phase has no length, so its words are not counted.
                        if (w_cur_state != c_st_data) begin
                            r_wcnt <= w_wcnt_base + c_wcnt_w'(1);
                            r_last <= w_last_word;
                        end
                    end else if (w_shift) begin
                        r_bitcnt     <= w_bit_dec;
                        r_frame      <= 1'b0;
                        r_word_ready <= (w_bit_dec == '0);
                        r_reset_out  <= r_rst_pend && (w_bit_dec == c_bit_rst);
                    end else begin
                        // Boundary or gap with no word: idle the lines and keep
                        // offering word_ready every cycle until one arrives.
                        r_active     <= 1'b0;
                        r_frame      <= 1'b0;
                        r_rst_pend   <= 1'b0;
                        r_reset_out  <= 1'b0;
                        r_word_ready <= 1'b1;
                        r_underrun   <= 1'b1;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    // Per-channel shift registers; r_sh holds the bits still to be sent,
    // left-aligned, while r_bit is the bit currently on the line.
    generate
        for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
            logic [FRAME_W-1:0] w_word;
            logic [FRAME_W-1:0] r_sh;
            logic               r_bit;

            assign w_word = word_data[g*FRAME_W +: FRAME_W] & w_mask;

            always_ff @(posedge Dclk or negedge Reset_n) begin
                if (!Reset_n) begin
                    r_sh  <= '0;
                    r_bit <= 1'b0;
                end else if (w_accept) begin
                    r_bit <= w_word[FRAME_W-1];
                    r_sh  <= {w_word[FRAME_W-2:0], 1'b0};
                end else if (w_shift) begin
                    r_bit <= r_sh[FRAME_W-1];
                    r_sh  <= {r_sh[FRAME_W-2:0], 1'b0};
                end else if (w_clear) begin
                    r_bit <= 1'b0;
                    r_sh  <= '0;
                end
            end

            assign Input[g] = r_bit;
        end
    endgenerate

    assign word_ready = r_word_ready;
    assign Frame      = r_frame;
    assign Reset_out  = r_reset_out;
    assign phase      = r_state[1:0];
    assign underrun   = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_msdap_frame_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_msdap_frame_tx
// Description : Self-checking bench for msdap_frame_tx. A driver pushes the
//               expected serial frame for each accepted word into a queue; a
//               monitor rebuilds frames from Frame/Input/Reset_out and
//               compares them against the queue.
// Revision    : 1.0  initial release
// ============================================================================
module tb_msdap_frame_tx;

    logic        Dclk = 1'b0;
    logic        Reset_n;
    logic        start;
    logic        skip_cfg;
    logic        dut_in_ready;
    logic        word_valid;
    logic [31:0] word_data;
    logic        word_rst;
    logic        word_ready;
    logic        Frame;
    logic [1:0]  Input;
    logic        Reset_out;
    logic [1:0]  phase;
    logic        underrun;

    always #5 Dclk = ~Dclk;

    msdap_frame_tx dut (
        .Dclk         (Dclk),
        .Reset_n      (Reset_n),
        .start        (start),
        .skip_cfg     (skip_cfg),
        .dut_in_ready (dut_in_ready),
        .word_valid   (word_valid),
        .word_data    (word_data),
        .word_rst     (word_rst),
        .word_ready   (word_ready),
        .Frame        (Frame),
        .Input        (Input),
        .Reset_out    (Reset_out),
        .phase        (phase),
        .underrun     (underrun)
    );

    typedef struct {
        logic [31:0] data;
        logic        rst;
        logic [1:0]  ph;
    } exp_t;

    exp_t        sb[$];
    int          n_checks    = 0;
    int          n_errors    = 0;
    int          cyc         = 0;
    int          mon_bit     = -1;
    bit          mon_en      = 1'b0;
    bit          chk_gapless = 1'b0;
    bit          mark_first  = 1'b0;
    int          last_start  = -1;
    int          last_delta  = 0;
    int          first_cyc   = -1;
    int          phase3_cyc  = -1;
    logic [1:0]  prev_phase  = 2'd0;
    logic [31:0] acc;
    logic [15:0] racc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%h, required 0x%h", name, act, req);
        end
    endtask

    // Offer one word and wait (bounded) for it to be taken; the expected
    // serial image is queued when acceptance is certain.
    task automatic send_word(input logic [31:0] d, input logic r,
                             input logic [31:0] ex, input logic [1:0] ph);
        int   b = 0;
        exp_t e;
        word_valid = 1'b1;
        word_data  = d;
        word_rst   = r;
        while (!word_ready && b < 100) begin
            @(negedge Dclk);
            b++;
        end
        if (!word_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL accept_timeout: word_ready=0 after %0d cycles, required 1", b);
        end else begin
            e.data = ex;
            e.rst  = r && (ph == 2'd3);
            e.ph   = ph;
            sb.push_back(e);
            @(negedge Dclk);
        end
        word_valid = 1'b0;
        word_rst   = 1'b0;
    endtask

    // Monitor: rebuilds frames, checks framing, idle lines and phase timing.
    always @(negedge Dclk) begin
        exp_t e;
        cyc++;
        if (phase == 2'd3 && prev_phase != 2'd3) phase3_cyc = cyc;
        prev_phase = phase;
        if (!mon_en) begin
            mon_bit = -1;
        end else if (Frame) begin
            check("frame_overlap", 32'(mon_bit + 1), 32'd0);
            if (mark_first) begin
                first_cyc  = cyc;
                mark_first = 1'b0;
            end
            if (last_start >= 0) begin
                last_delta = cyc - last_start;
                if (chk_gapless) check("gapless", 32'(last_delta), 32'd16);
            end
            last_start = cyc;
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL frame_unexpected: got a frame start, required none");
            end else begin
                check("frame_phase", 32'(phase), 32'(sb[0].ph));
            end
            mon_bit   = 15;
            acc       = '0;
            racc      = '0;
            acc[15]   = Input[0];
            acc[31]   = Input[1];
            racc[15]  = Reset_out;
        end else if (mon_bit > 0) begin
            mon_bit--;
            acc[mon_bit]      = Input[0];
            acc[16 + mon_bit] = Input[1];
            racc[mon_bit]     = Reset_out;
        end else begin
            check("idle_lines", 32'({Input, Reset_out}), 32'd0);
        end
        if (mon_en && mon_bit == 0) begin
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("frame_data", acc, e.data);
                check("frame_rst", 32'(racc), e.rst ? 32'h2000 : 32'h0);
            end
            mon_bit = -1;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int gate_bad;
        int gap_bad;
        int b;

        Reset_n      = 1'b0;
        start        = 1'b0;
        skip_cfg     = 1'b0;
        dut_in_ready = 1'b0;
        word_valid   = 1'b0;
        word_data    = '0;
        word_rst     = 1'b0;

        repeat (3) @(negedge Dclk);
        check("rst_frame",     32'(Frame),      32'd0);
        check("rst_input",     32'(Input),      32'd0);
        check("rst_reset_out", 32'(Reset_out),  32'd0);
        check("rst_ready",     32'(word_ready), 32'd0);
        check("rst_phase",     32'(phase),      32'd0);
        check("rst_underrun",  32'(underrun),   32'd0);
        Reset_n = 1'b1;
        mon_en  = 1'b1;
        @(negedge Dclk);

        // Gating on dut_in_ready; skip_cfg must only be taken with start.
        start    = 1'b1;
        skip_cfg = 1'b0;
        @(negedge Dclk);
        start    = 1'b0;
        skip_cfg = 1'b1;
        gate_bad = 0;
        repeat (20) begin
            @(negedge Dclk);
            if (phase != 2'd0 || word_ready != 1'b0) gate_bad++;
        end
        check("gate_hold", 32'(gate_bad), 32'd0);
        dut_in_ready = 1'b1;
        @(negedge Dclk);
        check("gate_rj_phase", 32'(phase),      32'd1);
        check("gate_ready",    32'(word_ready), 32'd1);

        // Configuration load: ch1 carries all-ones upper bits to check masking.
        chk_gapless = 1'b1;
        mark_first  = 1'b1;
        for (int j = 0; j < 16; j++)
            send_word({16'hFFFF, 16'h00A5}, (j == 15), {16'h00FF, 16'h00A5}, 2'd1);
        for (int i = 0; i < 512; i++)
            send_word({16'hFE00 | 16'(i), 16'h01FF}, (i == 0), {16'(i), 16'h01FF}, 2'd2);

        // Data phase, back to back, including reset injection.
        send_word({16'h1234, 16'h8001}, 1'b1, {16'h1234, 16'h8001}, 2'd3);
        send_word({16'h0000, 16'hFFFF}, 1'b0, {16'h0000, 16'hFFFF}, 2'd3);
        send_word({16'hA5C3, 16'h7FFE}, 1'b1, {16'hA5C3, 16'h7FFE}, 2'd3);
        check("phase3_time", 32'(phase3_cyc - first_cyc), 32'(528 * 16));
        check("no_underrun_cfg", 32'(underrun), 32'd0);

        // Underrun: word_valid low for the boundary cycle and four more.
        chk_gapless = 1'b0;
        b = 0;
        while (!word_ready && b < 100) begin
            @(negedge Dclk);
            b++;
        end
        check("boundary_ready", 32'(word_ready), 32'd1);
        gap_bad = 0;
        repeat (5) begin
            @(negedge Dclk);
            if (!word_ready || Frame) gap_bad++;
        end
        check("gap_ready", 32'(gap_bad), 32'd0);
        check("underrun_set", 32'(underrun), 32'd1);
        send_word({16'h0F0F, 16'hC001}, 1'b0, {16'h0F0F, 16'hC001}, 2'd3);
        @(negedge Dclk);
        check("gap_length", 32'(last_delta), 32'd21);

        // Asynchronous reset while bit 7 is on the lines.
        send_word({16'h00FF, 16'hAAAA}, 1'b0, {16'h00FF, 16'hAAAA}, 2'd3);
        repeat (8) @(negedge Dclk);
        mon_en = 1'b0;
        check("pre_reset_bits", 32'(Input), 32'd3);
        #2 Reset_n = 1'b0;
        #1;
        check("arst_frame",     32'(Frame),      32'd0);
        check("arst_input",     32'(Input),      32'd0);
        check("arst_reset_out", 32'(Reset_out),  32'd0);
        check("arst_ready",     32'(word_ready), 32'd0);
        check("arst_phase",     32'(phase),      32'd0);
        check("arst_underrun",  32'(underrun),   32'd0);
        sb.delete();
        last_start = -1;
        @(negedge Dclk);
        Reset_n = 1'b1;
        @(negedge Dclk);
        check("idle_phase", 32'(phase),      32'd0);
        check("idle_ready", 32'(word_ready), 32'd0);
        mon_en = 1'b1;

        // Restart straight into the data phase.
        skip_cfg     = 1'b1;
        dut_in_ready = 1'b1;
        start        = 1'b1;
        @(negedge Dclk);
        start    = 1'b0;
        skip_cfg = 1'b0;
        @(negedge Dclk);
        check("skip_phase", 32'(phase),      32'd3);
        check("skip_ready", 32'(word_ready), 32'd1);
        start = 1'b1;
        send_word({16'hFFFF, 16'h8001}, 1'b1, {16'hFFFF, 16'h8001}, 2'd3);
        start = 1'b0;
        send_word({16'h0001, 16'h2000}, 1'b0, {16'h0001, 16'h2000}, 2'd3);
        check("start_ignored", 32'(phase),    32'd3);
        check("skip_underrun", 32'(underrun), 32'd0);

        b = 0;
        while (sb.size() != 0 && b < 100) begin
            @(negedge Dclk);
            b++;
        end
        if (sb.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: %0d frames outstanding, required 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
